// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, ALU encodings, ID/EX control layout and immediate formats.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam int CTRL_ALU_OP_LSB = 8;
    localparam int CTRL_ALU_SRC    = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_FUNCT3_LSB = 0;

    // Field order matches the CTRL_* offsets above.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [2:0] funct3;
    } ctrl_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_e t);
        case (t)
            IMM_I:   gen_imm = {{21{i[31]}}, i[30:20]};
            IMM_S:   gen_imm = {{21{i[31]}}, i[30:25], i[11:7]};
            IMM_B:   gen_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   gen_imm = {i[31:12], 12'b0};
            IMM_J:   gen_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: gen_imm = '0;
        endcase
    endfunction

    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_funct = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_funct = ALU_SLL;
            3'b010:  alu_from_funct = ALU_SLT;
            3'b011:  alu_from_funct = ALU_SLTU;
            3'b100:  alu_from_funct = ALU_XOR;
            3'b101:  alu_from_funct = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_funct = ALU_OR;
            default: alu_from_funct = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 2-read/1-write register file; reads see a same-cycle write (write-first), x0 reads zero.
import rv32_pkg::*;

module id_regfile #(
    parameter int RF_DEPTH = 32,
    parameter int AW       = $clog2(RF_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [31:0]   rd1,
    output logic [31:0]   rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd
);

    logic [31:0] regs [RF_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
        if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: regfile, immediates, control, in-ID branch resolution, hazard stall and ID/EX register.
import rv32_pkg::*;

module id_stage #(
    parameter int KILL_SLOTS = 1,
    parameter int RF_DEPTH   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pc_plus_4,
    input  logic [31:0] if_instr,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [4:0]  ex_fwd_rd,
    input  logic        ex_fwd_we,
    input  logic [4:0]  mem_fwd_rd,
    input  logic        mem_fwd_we,
    output logic        pc_src,
    output logic [31:0] pc_branch_dest,
    output logic        stall,
    output logic        illegal,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_pc_plus_4,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [11:0] ex_ctrl
);

    localparam int KW = (KILL_SLOTS > 1) ? $clog2(KILL_SLOTS + 1) : 1;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    ctrl_t       ctrl;
    imm_type_e   imm_type;
    logic        known, use_rs1, use_rs2, is_branch, is_jal, is_jalr;
    logic        br_taken, killed, hazard, redirect, bubble;
    logic [KW-1:0] kill_cnt;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    id_regfile #(.RF_DEPTH(RF_DEPTH)) u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rs1_data),
        .rd2   (rs2_data),
        .we    (wb_we),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    always_comb begin
        ctrl      = '0;
        imm_type  = IMM_NONE;
        known     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OPC_LUI:    begin imm_type = IMM_U; ctrl.alu_op = ALU_PASSB; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OPC_AUIPC:  begin imm_type = IMM_U; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OPC_JAL:    begin imm_type = IMM_J; is_jal = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OPC_JALR: begin
                imm_type = IMM_I; is_jalr = 1'b1; use_rs1 = 1'b1;
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.funct3 = funct3;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B; is_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                ctrl.alu_op = ALU_SUB; ctrl.funct3 = funct3;
            end
            OPC_LOAD: begin
                imm_type = IMM_I; use_rs1 = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.funct3 = funct3;
            end
            OPC_STORE: begin
                imm_type = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.funct3 = funct3;
            end
            OPC_OPIMM: begin
                imm_type = IMM_I; use_rs1 = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.alu_op = alu_from_funct(funct3, funct3 == 3'b101 && if_instr[30]);
                ctrl.funct3 = funct3;
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.alu_op = alu_from_funct(funct3, if_instr[30]);
                ctrl.funct3 = funct3;
            end
            default: known = 1'b0;
        endcase
    end

    assign imm = gen_imm(if_instr, imm_type);

    always_comb begin
        case (funct3)
            3'b000:  br_taken = rs1_data == rs2_data;
            3'b001:  br_taken = rs1_data != rs2_data;
            3'b100:  br_taken = $signed(rs1_data) <  $signed(rs2_data);
            3'b101:  br_taken = $signed(rs1_data) >= $signed(rs2_data);
            3'b110:  br_taken = rs1_data <  rs2_data;
            3'b111:  br_taken = rs1_data >= rs2_data;
            default: br_taken = 1'b0;
        endcase
    end

    function automatic logic fwd_hit(input logic [4:0] r);
        return r != 5'd0 && ((ex_fwd_we && r == ex_fwd_rd) || (mem_fwd_we && r == mem_fwd_rd));
    endfunction

    // A killed slot is wrong-path: it must never stall, redirect or flag illegal.
    assign killed   = kill_cnt != '0;
    assign hazard   = !killed && ((use_rs1 && fwd_hit(rs1)) || (use_rs2 && fwd_hit(rs2)));
    assign redirect = !killed && !hazard && (is_jal || is_jalr || (is_branch && br_taken));
    assign bubble   = killed || hazard || !known;

    assign stall          = hazard && !reset;
    assign pc_src         = redirect && !reset;
    assign pc_branch_dest = is_jalr ? ((rs1_data + imm) & ~32'd1) : (if_pc + imm);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_cnt <= '0;
        end else if (redirect) begin
            kill_cnt <= KW'(KILL_SLOTS);
        end else if (killed) begin
            kill_cnt <= kill_cnt - KW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal      <= 1'b0;
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_pc_plus_4 <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_ctrl      <= '0;
        end else begin
            illegal <= !killed && !known;
            if (bubble) begin
                ex_valid     <= 1'b0;
                ex_pc        <= '0;
                ex_pc_plus_4 <= '0;
                ex_rs1_data  <= '0;
                ex_rs2_data  <= '0;
                ex_imm       <= '0;
                ex_rd        <= '0;
                ex_ctrl      <= '0;
            end else begin
                ex_valid     <= 1'b1;
                ex_pc        <= if_pc;
                ex_pc_plus_4 <= if_pc_plus_4;
                ex_rs1_data  <= rs1_data;
                ex_rs2_data  <= rs2_data;
                ex_imm       <= imm;
                ex_rd        <= ctrl.reg_write ? rd : 5'd0;
                ex_ctrl      <= ctrl;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: each issued instruction pushes its expected ID/EX bundle, popped one edge later.
import rv32_pkg::*;

module tb_id_stage;

    logic        clk, reset;
    logic [31:0] if_pc, if_pc_plus_4, if_instr;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  ex_fwd_rd, mem_fwd_rd;
    logic        ex_fwd_we, mem_fwd_we;
    logic        pc_src, stall, illegal, ex_valid;
    logic [31:0] pc_branch_dest, ex_pc, ex_pc_plus_4, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [11:0] ex_ctrl;

    id_stage #(.KILL_SLOTS(1), .RF_DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4), .if_instr(if_instr),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_fwd_rd(ex_fwd_rd), .ex_fwd_we(ex_fwd_we),
        .mem_fwd_rd(mem_fwd_rd), .mem_fwd_we(mem_fwd_we),
        .pc_src(pc_src), .pc_branch_dest(pc_branch_dest), .stall(stall), .illegal(illegal),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_plus_4(ex_pc_plus_4),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        ill;
        logic [31:0] pc, pc4, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [11:0] ctrl;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2, s1,
                                           input logic [2:0] f3, input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'h33};
    endfunction
    function automatic logic [31:0] i_type(input logic [11:0] im, input logic [4:0] s1,
                                           input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {im, s1, f3, d, op};
    endfunction
    function automatic logic [31:0] b_type(input logic [12:0] im, input logic [4:0] s2, s1, input logic [2:0] f3);
        return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_type(input logic [20:0] im, input logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'h6f};
    endfunction
    function automatic logic [11:0] mk_ctrl(input logic [3:0] alu, input logic src, mr, mw, rw, m2r,
                                            input logic [2:0] f3);
        return {alu, src, mr, mw, rw, m2r, f3};
    endfunction
    function automatic exp_t issued(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] rd,
                                    input logic [11:0] ctrl);
        exp_t e;
        e.valid = 1'b1; e.ill = 1'b0; e.pc = pc; e.pc4 = pc + 32'd4;
        e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd; e.ctrl = ctrl;
        return e;
    endfunction
    function automatic exp_t bubble(input logic ill);
        exp_t e;
        e.valid = 1'b0; e.ill = ill; e.pc = '0; e.pc4 = '0;
        e.rs1 = '0; e.rs2 = '0; e.imm = '0; e.rd = '0; e.ctrl = '0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one instruction, check the combinational outputs, then pop and check the bundle after the edge.
    task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic e_stall,
                        input logic e_src, input logic [31:0] e_dest, input exp_t e);
        exp_t got;
        if_pc = pc; if_pc_plus_4 = pc + 32'd4; if_instr = instr;
        #1;
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("pc_src", {31'd0, pc_src}, {31'd0, e_src});
        if (e_src) chk("pc_branch_dest", pc_branch_dest, e_dest);
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, got.valid});
            chk("illegal", {31'd0, illegal}, {31'd0, got.ill});
            chk("ex_pc", ex_pc, got.pc);
            chk("ex_pc_plus_4", ex_pc_plus_4, got.pc4);
            chk("ex_rs1_data", ex_rs1_data, got.rs1);
            chk("ex_rs2_data", ex_rs2_data, got.rs2);
            chk("ex_imm", ex_imm, got.imm);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, got.rd});
            chk("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, got.ctrl});
        end
    endtask

    initial begin
        logic [11:0] c_addi, c_add, c_jal;
        c_addi = mk_ctrl(ALU_ADD, 1, 0, 0, 1, 0, 3'b000);
        c_add  = mk_ctrl(ALU_ADD, 0, 0, 0, 1, 0, 3'b000);
        c_jal  = mk_ctrl(ALU_ADD, 1, 0, 0, 1, 0, 3'b000);

        reset = 1'b1; wb_we = 0; wb_rd = 0; wb_data = 0;
        ex_fwd_we = 0; ex_fwd_rd = 0; mem_fwd_we = 0; mem_fwd_rd = 0;
        if_pc = 32'h100; if_pc_plus_4 = 32'h104; if_instr = j_type(21'h20, 5'd1);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_ex_ctrl", {20'd0, ex_ctrl}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_pc_src", {31'd0, pc_src}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        // Same-cycle WB of x5 is bypassed into ADDI x6,x5,3.
        wb_we = 1; wb_rd = 5; wb_data = 32'h10;
        step(32'h0, i_type(12'd3, 5'd5, 3'b000, 5'd6, OPC_OPIMM), 0, 0, 0,
             issued(32'h0, 32'h10, 32'h0, 32'd3, 5'd6, c_addi));
        wb_rd = 1; wb_data = 32'hFFFF_FFFF;
        step(32'h4, NOP, 0, 0, 0, issued(32'h4, 0, 0, 0, 5'd0, c_addi));
        wb_rd = 2; wb_data = 32'h1;
        step(32'h8, NOP, 0, 0, 0, issued(32'h8, 0, 0, 0, 5'd0, c_addi));
        wb_rd = 3; wb_data = 32'h101;
        step(32'hC, NOP, 0, 0, 0, issued(32'hC, 0, 0, 0, 5'd0, c_addi));
        wb_we = 0;

        // EX hazard on rs1, then release.
        ex_fwd_we = 1; ex_fwd_rd = 5;
        step(32'h10, r_type(7'd0, 5'd1, 5'd5, 3'b000, 5'd7), 1, 0, 0, bubble(0));
        ex_fwd_we = 0; ex_fwd_rd = 0;
        step(32'h10, r_type(7'd0, 5'd1, 5'd5, 3'b000, 5'd7), 0, 0, 0,
             issued(32'h10, 32'h10, 32'hFFFF_FFFF, 0, 5'd7, c_add));
        // MEM hazard on rs2, then release.
        mem_fwd_we = 1; mem_fwd_rd = 2;
        step(32'h14, r_type(7'd0, 5'd2, 5'd5, 3'b000, 5'd7), 1, 0, 0, bubble(0));
        mem_fwd_we = 0;
        step(32'h14, r_type(7'd0, 5'd2, 5'd5, 3'b000, 5'd7), 0, 0, 0,
             issued(32'h14, 32'h10, 32'h1, 0, 5'd7, c_add));
        // rd==0 match and unused-rs2 match must not stall.
        ex_fwd_we = 1; ex_fwd_rd = 0; mem_fwd_we = 1; mem_fwd_rd = 5;
        step(32'h18, i_type(12'd5, 5'd0, 3'b000, 5'd8, OPC_OPIMM), 0, 0, 0,
             issued(32'h18, 0, 32'h10, 32'd5, 5'd8, c_addi));
        ex_fwd_we = 0; mem_fwd_we = 0; mem_fwd_rd = 0;

        // BEQ taken; the killed slot holds a JAL which must not redirect.
        step(32'h40, b_type(13'd16, 5'd0, 5'd0, 3'b000), 0, 1, 32'h50,
             issued(32'h40, 0, 0, 32'd16, 5'd0, mk_ctrl(ALU_SUB, 0, 0, 0, 0, 0, 3'b000)));
        step(32'h44, j_type(21'h20, 5'd1), 0, 0, 0, bubble(0));
        step(32'h50, NOP, 0, 0, 0, issued(32'h50, 0, 0, 0, 5'd0, c_addi));

        // Signed vs unsigned compare of -1 and 1.
        step(32'h60, b_type(13'd8, 5'd2, 5'd1, 3'b100), 0, 1, 32'h68,
             issued(32'h60, 32'hFFFF_FFFF, 32'h1, 32'd8, 5'd0, mk_ctrl(ALU_SUB, 0, 0, 0, 0, 0, 3'b100)));
        step(32'h64, NOP, 0, 0, 0, bubble(0));
        step(32'h68, b_type(13'd8, 5'd2, 5'd1, 3'b110), 0, 0, 0,
             issued(32'h68, 32'hFFFF_FFFF, 32'h1, 32'd8, 5'd0, mk_ctrl(ALU_SUB, 0, 0, 0, 0, 0, 3'b110)));
        step(32'h6C, NOP, 0, 0, 0, issued(32'h6C, 0, 0, 0, 5'd0, c_addi));

        // JALR clears bit 0 of the target.
        step(32'h80, i_type(12'd8, 5'd3, 3'b000, 5'd1, OPC_JALR), 0, 1, 32'h108,
             issued(32'h80, 32'h101, 32'h0, 32'd8, 5'd1, c_jal));
        step(32'h84, NOP, 0, 0, 0, bubble(0));

        // Unknown opcode: illegal pulse for exactly one cycle.
        step(32'h90, 32'h0000_007F, 0, 0, 0, bubble(1));
        step(32'h94, NOP, 0, 0, 0, issued(32'h94, 0, 0, 0, 5'd0, c_addi));

        // Reset asserted inside a kill slot clears the bundle and the kill counter.
        step(32'hA0, b_type(13'd16, 5'd0, 5'd0, 3'b000), 0, 1, 32'hB0,
             issued(32'hA0, 0, 0, 32'd16, 5'd0, mk_ctrl(ALU_SUB, 0, 0, 0, 0, 0, 3'b000)));
        if_pc = 32'hA4; if_pc_plus_4 = 32'hA8; if_instr = NOP;
        reset = 1'b1;
        #1;
        chk("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_ex_pc", ex_pc, 32'd0);
        chk("midrst_pc_src", {31'd0, pc_src}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(32'hC0, j_type(21'h20, 5'd1), 0, 1, 32'hE0, issued(32'hC0, 0, 0, 32'h20, 5'd1, c_jal));
        step(32'hC4, NOP, 0, 0, 0, bubble(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
